// File: rtl/prio_pkg.sv
// Shared constants and helpers for the priority-encoder family.
package prio_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Index width for an N-input encoder; a single input still gets one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/prio_enc_comb.sv
// Combinational priority encoder: highest set index wins.
module prio_enc_comb
    import prio_pkg::*;
#(
    parameter int N = 8,
    parameter int W = idx_width(N)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         any
);

    // Ascending scan so a higher set bit overwrites any lower one.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (vec[k]) begin
                idx = W'(k);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/prio_enc_rr.sv
// Registered N-input priority encoder with optional round-robin arbitration
// and a valid/ready output handshake. All outputs come straight from flops.
module prio_enc_rr
    import prio_pkg::*;
#(
    parameter int N = 8,
    parameter int W = idx_width(N)   // derived; leave at default
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         rr_en,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_idx,
    output logic [N-1:0] out_onehot,
    output logic         out_multi
);

    localparam logic [W-1:0] PTR_MAX = W'(N - 1);

    logic         valid_q, valid_d;
    logic [W-1:0] idx_q, idx_d;
    logic [N-1:0] onehot_q, onehot_d;
    logic         multi_q, multi_d;
    logic [W-1:0] ptr_q, ptr_d;

    logic         load, accept;
    logic [N-1:0] mask, masked;
    logic [W-1:0] m_idx, u_idx, grant_idx;
    logic         m_any, u_any;

    assign accept = valid_q & out_ready;
    assign load   = ~valid_q | out_ready;

    // Pointer steps just below the grant being accepted; the search that
    // loads on this same edge already uses the stepped value, which is what
    // keeps back-to-back round-robin grants rotating at one per cycle.
    always_comb begin
        ptr_d = ptr_q;
        if (accept && (rr_en == MODE_RR)) begin
            ptr_d = (idx_q == '0) ? PTR_MAX : (idx_q - W'(1));
        end
    end

    // Thermometer mask covering bits [ptr:0] of the request vector.
    always_comb begin
        mask = '0;
        for (int k = 0; k < N; k++) begin
            mask[k] = (W'(k) <= ptr_d);
        end
    end

    assign masked = req & mask;

    prio_enc_comb #(.N(N), .W(W)) u_enc_masked (
        .vec (masked),
        .idx (m_idx),
        .any (m_any)
    );

    prio_enc_comb #(.N(N), .W(W)) u_enc_full (
        .vec (req),
        .idx (u_idx),
        .any (u_any)
    );

    assign grant_idx = ((rr_en == MODE_RR) && m_any) ? m_idx : u_idx;

    // Next result: capture a fresh encode on load, otherwise hold bit-stable.
    always_comb begin
        valid_d  = valid_q;
        idx_d    = idx_q;
        onehot_d = onehot_q;
        multi_d  = multi_q;
        if (load) begin
            valid_d  = u_any;
            idx_d    = u_any ? grant_idx : '0;
            multi_d  = ((req & (req - N'(1))) != '0);
            onehot_d = '0;
            for (int k = 0; k < N; k++) begin
                onehot_d[k] = u_any && (grant_idx == W'(k));
            end
        end
    end

    // Output and pointer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            idx_q    <= '0;
            onehot_q <= '0;
            multi_q  <= 1'b0;
            ptr_q    <= PTR_MAX;
        end else begin
            valid_q  <= valid_d;
            idx_q    <= idx_d;
            onehot_q <= onehot_d;
            multi_q  <= multi_d;
            ptr_q    <= ptr_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_idx    = idx_q;
    assign out_onehot = onehot_q;
    assign out_multi  = multi_q;

endmodule

// File: tb/tb_prio_enc_rr.sv
// Self-checking bench for prio_enc_rr (N = 8) with a behavioural scoreboard.
module tb_prio_enc_rr;

    typedef struct packed {
        logic       v;
        logic [2:0] idx;
        logic [7:0] oh;
        logic       m;
    } res_t;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       rr_en;
    logic       out_ready;
    logic       out_valid;
    logic [2:0] out_idx;
    logic [7:0] out_onehot;
    logic       out_multi;

    int   n_cmp;
    int   n_mis;
    res_t exp_q[$];
    res_t mdl;
    int   mptr;
    res_t e;

    prio_enc_rr #(.N(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .rr_en      (rr_en),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_idx    (out_idx),
        .out_onehot (out_onehot),
        .out_multi  (out_multi)
    );

    always #5 clk = ~clk;

    function automatic res_t dut_out();
        return '{out_valid, out_idx, out_onehot, out_multi};
    endfunction

    function automatic string fmt(input res_t r);
        return $sformatf("v=%b idx=%0d oh=%h multi=%b", r.v, r.idx, r.oh, r.m);
    endfunction

    // An empty queue yields all-X so the following compare reports it.
    function automatic res_t pop_exp();
        res_t r;
        r = 'x;
        if (exp_q.size() > 0) r = exp_q.pop_front();
        return r;
    endfunction

    // Drive one cycle, advance the reference model, push its prediction.
    task automatic drive(input logic r, input logic [7:0] rq, input logic rr, input logic rdy);
        logic acc, ld;
        int   g;
        bit   found;
        rst = r; req = rq; rr_en = rr; out_ready = rdy;
        if (r) begin
            mdl  = '0;
            mptr = 7;
        end else begin
            acc = mdl.v && rdy;
            ld  = !mdl.v || rdy;
            if (acc && rr) mptr = (mdl.idx == 0) ? 7 : int'(mdl.idx) - 1;
            if (ld) begin
                mdl = '0;
                if (rq != 0) begin
                    g = 0; found = 0;
                    if (rr) begin
                        for (int s = 0; s < 8; s++) begin
                            int k;
                            k = (mptr - s + 8) % 8;
                            if (!found && rq[k]) begin g = k; found = 1; end
                        end
                    end else begin
                        for (int k = 7; k >= 0; k--) begin
                            if (!found && rq[k]) begin g = k; found = 1; end
                        end
                    end
                    mdl.v   = 1'b1;
                    mdl.idx = 3'(g);
                    mdl.oh  = 8'(1) << g;
                    mdl.m   = ($countones(rq) > 1);
                end
            end
        end
        exp_q.push_back(mdl);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1, 8'hFF, 0, 1);
        e = pop_exp(); n_cmp++;
        if (dut_out() !== e) begin n_mis++; $display("FAIL reset_c1: got %s exp %s", fmt(dut_out()), fmt(e)); end
        drive(1, 8'hFF, 0, 1);
        e = pop_exp(); n_cmp++;
        if (dut_out() !== e) begin n_mis++; $display("FAIL reset_c2: got %s exp %s", fmt(dut_out()), fmt(e)); end
        n_cmp++;
        if (dut_out() !== res_t'{1'b0, 3'd0, 8'h00, 1'b0}) begin n_mis++; $display("FAIL reset_state: got %s exp all zero", fmt(dut_out())); end
        drive(0, 8'h80, 0, 1);
        e = pop_exp(); n_cmp++;
        if (dut_out() !== e) begin n_mis++; $display("FAIL reset_release: got %s exp %s", fmt(dut_out()), fmt(e)); end
        n_cmp++;
        if (dut_out() !== res_t'{1'b1, 3'd7, 8'h80, 1'b0}) begin n_mis++; $display("FAIL reset_first_grant: got %s exp idx=7", fmt(dut_out())); end
    endtask

    task automatic test_fixed();
        for (int i = 0; i < 4; i++) begin
            drive(0, 8'b0010_0110, 0, 1);
            e = pop_exp(); n_cmp++;
            if (dut_out() !== e) begin n_mis++; $display("FAIL fixed_sb[%0d]: got %s exp %s", i, fmt(dut_out()), fmt(e)); end
            n_cmp++;
            if (dut_out() !== res_t'{1'b1, 3'd5, 8'h20, 1'b1}) begin n_mis++; $display("FAIL fixed_idx5[%0d]: got %s exp idx=5", i, fmt(dut_out())); end
        end
        drive(0, 8'h00, 0, 1);
        e = pop_exp(); n_cmp++;
        if (dut_out() !== e) begin n_mis++; $display("FAIL fixed_zero: got %s exp %s", fmt(dut_out()), fmt(e)); end
        n_cmp++;
        if (out_valid !== 1'b0) begin n_mis++; $display("FAIL fixed_zero_valid: got %b exp 0", out_valid); end
    endtask

    task automatic test_backpressure();
        drive(0, 8'h04, 0, 0);
        e = pop_exp(); n_cmp++;
        if (dut_out() !== e) begin n_mis++; $display("FAIL bp_load: got %s exp %s", fmt(dut_out()), fmt(e)); end
        n_cmp++;
        if (out_idx !== 3'd2) begin n_mis++; $display("FAIL bp_load_idx: got %0d exp 2", out_idx); end
        for (int i = 0; i < 3; i++) begin
            drive(0, 8'h40, 0, 0);
            e = pop_exp(); n_cmp++;
            if (dut_out() !== e) begin n_mis++; $display("FAIL bp_stall_sb[%0d]: got %s exp %s", i, fmt(dut_out()), fmt(e)); end
            n_cmp++;
            if (out_idx !== 3'd2 || out_valid !== 1'b1) begin n_mis++; $display("FAIL bp_hold[%0d]: got v=%b idx=%0d exp v=1 idx=2", i, out_valid, out_idx); end
        end
        drive(0, 8'h40, 0, 1);
        e = pop_exp(); n_cmp++;
        if (dut_out() !== e) begin n_mis++; $display("FAIL bp_release: got %s exp %s", fmt(dut_out()), fmt(e)); end
        n_cmp++;
        if (out_idx !== 3'd6) begin n_mis++; $display("FAIL bp_release_idx: got %0d exp 6", out_idx); end
    endtask

    task automatic test_rr_full();
        int seq[10] = '{7, 6, 5, 4, 3, 2, 1, 0, 7, 6};
        drive(1, 8'h00, 1, 1);
        e = pop_exp();
        for (int i = 0; i < 10; i++) begin
            drive(0, 8'hFF, 1, 1);
            e = pop_exp(); n_cmp++;
            if (dut_out() !== e) begin n_mis++; $display("FAIL rr_full_sb[%0d]: got %s exp %s", i, fmt(dut_out()), fmt(e)); end
            n_cmp++;
            if (out_idx !== 3'(seq[i]) || out_multi !== 1'b1) begin n_mis++; $display("FAIL rr_full_seq[%0d]: got idx=%0d multi=%b exp idx=%0d multi=1", i, out_idx, out_multi, seq[i]); end
        end
    endtask

    task automatic test_rr_sparse();
        int seq[9] = '{7, 0, 7, 0, 0, 0, 0, 0, 7};
        logic rdy;
        drive(1, 8'h00, 1, 1);
        e = pop_exp();
        for (int i = 0; i < 9; i++) begin
            rdy = (i < 4 || i == 8);
            drive(0, 8'b1000_0001, 1, rdy);
            e = pop_exp(); n_cmp++;
            if (dut_out() !== e) begin n_mis++; $display("FAIL rr_sparse_sb[%0d]: got %s exp %s", i, fmt(dut_out()), fmt(e)); end
            n_cmp++;
            if (out_idx !== 3'(seq[i]) || out_valid !== 1'b1) begin n_mis++; $display("FAIL rr_sparse_seq[%0d]: got v=%b idx=%0d exp v=1 idx=%0d", i, out_valid, out_idx, seq[i]); end
        end
    endtask

    task automatic test_reset_mid_stall();
        drive(1, 8'h00, 1, 1);
        e = pop_exp();
        for (int i = 0; i < 5; i++) begin
            drive(0, 8'hFF, 1, 1);
            e = pop_exp();
        end
        drive(0, 8'hFF, 1, 0);
        e = pop_exp(); n_cmp++;
        if (dut_out() !== e || out_idx !== 3'd3) begin n_mis++; $display("FAIL mid_stall_hold: got %s exp %s", fmt(dut_out()), fmt(e)); end
        drive(1, 8'hFF, 1, 0);
        e = pop_exp(); n_cmp++;
        if (dut_out() !== e || out_valid !== 1'b0) begin n_mis++; $display("FAIL mid_stall_reset: got %s exp %s", fmt(dut_out()), fmt(e)); end
        drive(0, 8'hFF, 1, 1);
        e = pop_exp(); n_cmp++;
        if (dut_out() !== e || out_idx !== 3'd7) begin n_mis++; $display("FAIL mid_stall_ptr: got %s exp idx=7", fmt(dut_out())); end
    endtask

    task automatic test_random();
        logic [7:0] rq;
        drive(1, 8'h00, 0, 1);
        e = pop_exp();
        for (int i = 0; i < 300; i++) begin
            rq = 8'($urandom);
            if ($urandom_range(0, 3) == 0) rq = rq & 8'($urandom);
            if ($urandom_range(0, 9) == 0) rq = 8'h00;
            drive(0, rq, 1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7));
            e = pop_exp(); n_cmp++;
            if (dut_out() !== e) begin n_mis++; $display("FAIL random[%0d]: req=%h got %s exp %s", i, rq, fmt(dut_out()), fmt(e)); end
        end
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1; req = '0; rr_en = 1'b0; out_ready = 1'b0;
        n_cmp = 0; n_mis = 0; mdl = '0; mptr = 7;
        @(posedge clk);
        #1;
        test_reset();
        test_fixed();
        test_backpressure();
        test_rr_full();
        test_rr_sparse();
        test_reset_mid_stall();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/prio_enc_rr.md
Name: prio_enc_rr

Overview:
Registered, parametrised N-input priority encoder. It is the successor of the 8-bit combinational priority encoder.
- Adds a runtime-selectable round-robin mode, so a persistent high-index request cannot starve lower indices.
- Adds a valid/ready output handshake, so a downstream consumer can stall the result.
- Sits between the TT user-project input pins (or internal request sources) and a consumer that services one index at a time.

Parameters:
N, 8, number of request lines (N >= 1).
W, (N>1)?$clog2(N):1, width of the encoded index (derived; never overridden).

Ports:
clk  input  1  system clock; all state updates on its rising edge.
rst  input  1  synchronous, active-high reset.
req  input  N  request vector; bit k = requester k.
rr_en  input  1  0 = fixed priority (highest index wins); 1 = round-robin.
out_ready  input  1  consumer accepts the current result this cycle.
out_valid  output  1  out_idx/out_onehot hold a valid grant.
out_idx  output  W  encoded index of the granted request.
out_onehot  output  N  one-hot form of the grant; zero when out_valid = 0.
out_multi  output  1  more than one req bit was set when the result was loaded.

Behaviour:
- Reset (rst = 1 at a clock edge) is synchronous and active-high. It overrides everything, including a stall in progress. After reset:
  - out_valid = 0, out_idx = 0, out_onehot = 0, out_multi = 0.
  - Round-robin pointer ptr = N-1.
- Load condition: load = !out_valid | out_ready. When load is true, the output register captures the encode of the current req. Latency is exactly 1 cycle from req to outputs.
- Load with req == 0: out_valid <= 0, out_idx <= 0, out_onehot <= 0, out_multi <= 0.
- Stall (out_valid & !out_ready): all outputs hold bit-stable and req is ignored. A request that rises and falls during a stall is lost; this is intended, since req is level-based.
- Accept: a handshake (out_valid & out_ready) is an accept. On accept the result is consumed, and the same edge loads the next encode. Back-to-back grants therefore run at 1 per cycle.
- Fixed mode (rr_en = 0): grant = highest set index.
- Round-robin mode (rr_en = 1): search order is ptr, ptr-1, ..., 0, N-1, ..., ptr+1, and the first set bit wins.
  - Implement this as a masked/unmasked pair. Masked = req & bits[ptr:0]. If masked != 0, encode masked; otherwise encode req.
- Pointer update:
  - ptr updates only on an accept while rr_en = 1: ptr <= (granted idx == 0) ? N-1 : idx-1.
  - ptr is unchanged in fixed mode.
  - ptr is not reset when rr_en toggles.
  - rr_en is sampled at load time only; a toggle during a stall affects the next load.
- Out-of-range values are impossible: ptr is always in 0..N-1, including when N is not a power of two.
- out_multi is registered together with the grant and follows the same stall/load rules. It is computed as popcount(req) > 1, evaluated via (req & (req-1)) != 0.
- N = 1: out_idx is always 0, out_multi is always 0, and round-robin degenerates to fixed mode.
- No combinational path from any input to any output.

Decomposition:
- Shared package prio_pkg:
  - Mode constants MODE_FIXED = 1'b0 and MODE_RR = 1'b1.
  - A function that returns the index-width for a given N (the W rule above).
- One sub-module, prio_enc_comb:
  - Parameter N; inputs vec[N]; outputs idx[W], any.
  - Purely combinational encoder, highest index first.
  - Instantiated twice in prio_enc_rr: once on the masked vector, once on the unmasked vector.
- Top level contains the output register, the load logic, the ptr register and the mask generation.

Test Plan:
1. Reset: N=8, req=8'hFF, rst=1 for 2 cycles -> out_valid=0, out_idx=0, out_onehot=0. Release rst with req=8'h80, out_ready=1 -> one cycle later out_valid=1, out_idx=7, out_onehot=8'h80, out_multi=0.
2. Fixed priority: rr_en=0, out_ready=1, req=8'b0010_0110 held -> out_idx=5 every cycle, out_onehot=8'h20, out_multi=1. Then req=0 -> out_valid=0 next cycle.
3. Backpressure: out_ready=0, req=8'h04 -> out_idx=2. Change req to 8'h40 for 3 cycles -> out_idx stays 2, out_valid stays 1. Raise out_ready -> out_idx=6 on the following cycle.
4. Round-robin full load: rr_en=1, out_ready=1, req=8'hFF held -> out_idx sequence 7,6,5,4,3,2,1,0,7,6; out_multi=1 throughout.
5. Round-robin wrap and sparse requests: rr_en=1, req=8'b1000_0001 -> 7,0,7,0. Stalling with out_ready=0 on idx 0 for 4 cycles -> idx 0 held, ptr unchanged; after accept, next grant = 7.
6. Reset mid-stall: in round-robin with ptr=3 and out_valid=1, out_ready=0, assert rst one cycle -> out_valid=0 next cycle. Then req=8'hFF -> first grant idx 7, confirming ptr was reset to N-1.
